// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: logic/arith ops register in one cycle, shifts iterate one bit per cycle.
// Result is held under OutValid until OutReady; InReady is low from acceptance until release.
module alu_exec_unit #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [3:0]       Operation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_SLT = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_SUB = 4'b1100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic                 sra_q, sra_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 ovf_q, ovf_d;

    logic [WIDTH-1:0]     sum;
    logic [WIDTH-1:0]     diff;
    logic                 add_ovf;
    logic                 sub_ovf;
    logic                 slt_bit;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_ovf;
    logic [SHAMT_W-1:0]   shamt;
    logic                 is_shift;
    logic [WIDTH-1:0]     acc_step;

    assign sum     = A + B;
    assign diff    = A - B;
    assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
    // Signed less-than from the subtractor: sign corrected by overflow.
    assign slt_bit = diff[WIDTH-1] ^ sub_ovf;

    assign shamt    = B[SHAMT_W-1:0];
    assign is_shift = (Operation == OP_SLL) || (Operation == OP_SRA);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (Operation)
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = add_ovf;
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = sub_ovf;
            end
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
            // Only reached on the single-cycle path, i.e. shift by zero.
            OP_SLL, OP_SRA: alu_res = A;
            default: alu_res = '0;
        endcase
    end

    assign acc_step = sra_q ? {acc_q[WIDTH-1], acc_q[WIDTH-1:1]}
                            : {acc_q[WIDTH-2:0], 1'b0};

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sra_d    = sra_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (InValid) begin
                    if (is_shift && (shamt != '0)) begin
                        acc_d   = A;
                        cnt_d   = shamt;
                        sra_d   = (Operation == OP_SRA);
                        state_d = SHIFT;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        ovf_d    = alu_ovf;
                        state_d  = DONE;
                    end
                end
            end
            SHIFT: begin
                acc_d = acc_step;
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d = acc_step;
                    zero_d   = (acc_step == '0);
                    ovf_d    = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (OutReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            sra_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sra_q    <= sra_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign InReady  = (state_q == IDLE);
    assign OutValid = (state_q == DONE);
    assign Result   = result_q;
    assign Zero     = zero_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed vector bench for alu_exec_unit with hand-written handshake and reset sequences.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        InValid;
    logic        InReady;
    logic [3:0]  Operation;
    logic [15:0] A;
    logic [15:0] B;
    logic        OutValid;
    logic        OutReady;
    logic [15:0] Result;
    logic        Zero;
    logic        Overflow;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk(clk), .reset(reset),
        .InValid(InValid), .InReady(InReady),
        .Operation(Operation), .A(A), .B(B),
        .OutValid(OutValid), .OutReady(OutReady),
        .Result(Result), .Zero(Zero), .Overflow(Overflow)
    );

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        z;
        logic        o;
        int          wait_cyc;   // edges after the acceptance edge until OutValid
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic do_op(input vec_t v, input string name);
        int edges;
        @(negedge clk);
        check({name, "_inready"}, 32'(InReady), 32'd1);
        Operation = v.op; A = v.a; B = v.b;
        InValid = 1'b1; OutReady = 1'b1;
        @(posedge clk); #1;
        InValid = 1'b0;
        edges = 0;
        while (!OutValid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check({name, "_latency"}, 32'(edges), 32'(v.wait_cyc));
        check({name, "_result"}, 32'(Result), 32'(v.res));
        check({name, "_zero"}, 32'(Zero), 32'(v.z));
        check({name, "_ovf"}, 32'(Overflow), 32'(v.o));
        @(posedge clk); #1;
        check({name, "_released"}, 32'(OutValid), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{4'b0100, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 0};
        vecs[1]  = '{4'b1100, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 0};
        vecs[2]  = '{4'b0001, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 0};
        vecs[3]  = '{4'b0001, 16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0};
        vecs[4]  = '{4'b0000, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 0};
        vecs[5]  = '{4'b0010, 16'h0F00, 16'h00F0, 16'h0FF0, 1'b0, 1'b0, 0};
        vecs[6]  = '{4'b0011, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b1, 1'b0, 0};
        vecs[7]  = '{4'b0100, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 0};
        vecs[8]  = '{4'b1100, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 0};
        vecs[9]  = '{4'b0001, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0};
        vecs[10] = '{4'b1111, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0, 0};
        vecs[11] = '{4'b0111, 16'h8000, 16'h0004, 16'hF800, 1'b0, 1'b0, 4};
        vecs[12] = '{4'b0110, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 15};
        vecs[13] = '{4'b0110, 16'h1234, 16'h0010, 16'h1234, 1'b0, 1'b0, 0};
        vecs[14] = '{4'b0111, 16'h7FF0, 16'h0004, 16'h07FF, 1'b0, 1'b0, 4};
        vecs[15] = '{4'b0111, 16'h8001, 16'h000F, 16'hFFFF, 1'b0, 1'b0, 15};
        vecs[16] = '{4'b0110, 16'h8000, 16'h0001, 16'h0000, 1'b1, 1'b0, 1};

        reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
        Operation = 4'b0000; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", 32'(Result), 32'd0);
        check("rst_zero", 32'(Zero), 32'd0);
        check("rst_ovf", 32'(Overflow), 32'd0);
        check("rst_outvalid", 32'(OutValid), 32'd0);
        @(negedge clk); reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // InReady stays low while a 4-bit SRA is iterating.
        @(negedge clk);
        Operation = 4'b0111; A = 16'h8000; B = 16'h0004;
        InValid = 1'b1; OutReady = 1'b1;
        @(posedge clk); #1;
        InValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("sra_busy%0d", k), 32'({InReady, OutValid}), 32'd0);
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        check("sra_done", 32'({OutValid, Result}), 32'h1F800);
        @(posedge clk); #1;

        // Backpressure: result held for 5 cycles, a competing request is ignored.
        @(negedge clk);
        Operation = 4'b0011; A = 16'hFF00; B = 16'h0FF0;
        InValid = 1'b1; OutReady = 1'b0;
        @(posedge clk); #1;
        Operation = 4'b0100; A = 16'h0001; B = 16'h0001;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_hold%0d", k),
                  32'({OutValid, InReady, Zero, Overflow, Result}), 32'h8F0F0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        OutReady = 1'b1; InValid = 1'b0;
        @(posedge clk); #1;
        check("bp_release", 32'({OutValid, InReady}), 32'd1);
        check("bp_not_taken", 32'(Result), 32'hF0F0);

        // Reset in the 3rd cycle of an SRA by 8.
        @(negedge clk);
        Operation = 4'b0111; A = 16'h8000; B = 16'h0008;
        InValid = 1'b1; OutReady = 1'b1;
        @(posedge clk); #1;
        InValid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_outputs", 32'({OutValid, Zero, Overflow, Result}), 32'd0);
        @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check($sformatf("midrst_idle%0d", k), 32'({OutValid, InReady}), 32'd1);
        end
        do_op('{4'b0100, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 0}, "post_rst_add");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
